// File: rtl/tpu_axi_pkg.sv
// Shared AXI constants and state encoding for the TPU writeback DMA.
package tpu_axi_pkg;

    localparam logic [1:0]  BURST_INCR  = 2'b01;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [12:0] BOUNDARY_4K = 13'h1000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AW   = 3'd1,
        ST_W    = 3'd2,
        ST_B    = 3'd3,
        ST_DONE = 3'd4
    } wb_state_e;

    // Unsigned minimum used when sizing bursts.
    function automatic logic [16:0] min17(input logic [16:0] a, input logic [16:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_writeback_dma_if.sv
// AXI4 write-channel bundle (AW, W, B) between the DMA master and DDR slave.
interface axi_writeback_dma_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic [31:0]             awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/wb_data_fifo.sv
// Synchronous data FIFO between buffer prefetch and the AXI W channel.
// Read data is registered: a pop loads rd_data on the following edge and
// rd_data then holds until the next pop.
module wb_data_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    // Next pointer, occupancy and output-register values.
    always_comb begin
        wr_ptr_d  = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d  = rd_en ? rd_ptr_q + PW'(1) : rd_ptr_q;
        rd_data_d = rd_en ? mem_q[rd_ptr_q] : rd_data_q;
        count_d   = count_q + (PW+1)'(wr_en) - (PW+1)'(rd_en);
    end

    // Control state, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = rd_data_q;
    assign count   = count_q;
endmodule

// File: rtl/axi_writeback_dma.sv
// Single-channel writeback DMA: unified buffer -> DDR over AXI4 INCR bursts.
// One burst outstanding; bursts capped at MAX_BURST beats and never cross
// a 4 KB page. Buffer prefetch runs ahead under credit control so the data
// FIFO can never overflow.
module axi_writeback_dma
    import tpu_axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_pulse,
    input  logic [31:0]           dest_addr,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [15:0]           length,
    output logic                  done_irq,
    output logic                  busy,
    output logic                  err_bresp,
    output logic                  buf_rd_en,
    output logic [ADDR_WIDTH-1:0] buf_rd_addr,
    input  logic [DATA_WIDTH-1:0] buf_rd_data,
    axi_writeback_dma_if.master   m_axi
);
    localparam int          BYTES      = DATA_WIDTH / 8;
    localparam int          BYTE_SHIFT = $clog2(BYTES);
    localparam int          CW         = $clog2(FIFO_DEPTH);
    localparam logic [2:0]  AWSIZE     = 3'(BYTE_SHIFT);
    localparam logic [31:0] ALIGN_MASK = ~32'(BYTES - 1);

    // Beats for the next burst: bounded by words left, MAX_BURST and the 4 KB page.
    function automatic logic [8:0] burst_beats(input logic [11:0] addr_lo, input logic [15:0] rem);
        logic [12:0] to_bound;
        logic [16:0] lim;
        to_bound = BOUNDARY_4K - {1'b0, addr_lo};
        lim      = min17({1'b0, rem}, 17'(MAX_BURST));
        lim      = min17(lim, 17'(to_bound >> BYTE_SHIFT));
        return 9'(lim);
    endfunction

    wb_state_e             state_q, state_d;
    logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [15:0]           remaining_q, remaining_d;
    logic [8:0]            beats_q, beats_d, pop_cnt_q, pop_cnt_d;
    logic [31:0]           awaddr_q, awaddr_d;
    logic [7:0]            awlen_q, awlen_d;
    logic [2:0]            awsize_q, awsize_d;
    logic [1:0]            awburst_q, awburst_d;
    logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic                  wlast_q, wlast_d, bready_q, bready_d;
    logic [15:0]           wtr_q, wtr_d;
    logic [CW:0]           used_q, used_d;
    logic                  rd_en_q, rd_en_d, push_q, push_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;

    logic                  start_acc_s, aw_hs_s, w_hs_s, b_hs_s, fifo_pop_s;
    logic [CW:0]           fifo_count_s;
    logic [DATA_WIDTH-1:0] fifo_rd_data_s;
    logic [31:0]           nxt_addr_s;
    logic [15:0]           nxt_rem_s;
    logic [8:0]            nxt_beats_s, start_beats_s;

    assign start_acc_s = (state_q == ST_IDLE) && start_pulse;
    assign aw_hs_s     = awvalid_q && m_axi.awready;
    assign w_hs_s      = wvalid_q && m_axi.wready;
    assign b_hs_s      = bready_q && m_axi.bvalid;
    // Pop only to refill an empty or just-accepted W register, and never
    // beyond the current burst's beat count.
    assign fifo_pop_s  = (state_q == ST_W) && (pop_cnt_q != beats_q) &&
                         (fifo_count_s != '0) && (!wvalid_q || m_axi.wready);

    wb_data_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_q),
        .wr_data (buf_rd_data),
        .rd_en   (fifo_pop_s),
        .rd_data (fifo_rd_data_s),
        .count   (fifo_count_s)
    );

    // Transfer FSM, AW/B channel and W beat sequencing.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        remaining_d = remaining_q;
        beats_d     = beats_q;
        awaddr_d    = awaddr_q;
        awlen_d     = awlen_q;
        awsize_d    = awsize_q;
        awburst_d   = awburst_q;
        awvalid_d   = awvalid_q;
        bready_d    = bready_q;

        nxt_addr_s    = awaddr_q + (32'(beats_q) << BYTE_SHIFT);
        nxt_rem_s     = remaining_q - 16'(beats_q);
        nxt_beats_s   = burst_beats(nxt_addr_s[11:0], nxt_rem_s);
        start_beats_s = burst_beats(dest_addr[11:0] & ALIGN_MASK[11:0], length);

        if (fifo_pop_s) begin
            wvalid_d  = 1'b1;
            wlast_d   = (pop_cnt_q == beats_q - 9'd1);
            pop_cnt_d = pop_cnt_q + 9'd1;
        end else if (w_hs_s) begin
            wvalid_d  = 1'b0;
            wlast_d   = 1'b0;
            pop_cnt_d = pop_cnt_q;
        end else begin
            wvalid_d  = wvalid_q;
            wlast_d   = wlast_q;
            pop_cnt_d = pop_cnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_pulse) begin
                    busy_d      = 1'b1;
                    err_d       = 1'b0;
                    remaining_d = length;
                    if (length == 16'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_AW;
                        awaddr_d  = dest_addr & ALIGN_MASK;
                        awlen_d   = 8'(start_beats_s - 9'd1);
                        beats_d   = start_beats_s;
                        awsize_d  = AWSIZE;
                        awburst_d = BURST_INCR;
                        awvalid_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_AW: begin
                if (aw_hs_s) begin
                    awvalid_d = 1'b0;
                    pop_cnt_d = 9'd0;
                    state_d   = ST_W;
                end else begin
                    state_d = ST_AW;
                end
            end
            ST_W: begin
                if (w_hs_s && wlast_q) begin
                    bready_d = 1'b1;
                    state_d  = ST_B;
                end else begin
                    state_d = ST_W;
                end
            end
            ST_B: begin
                if (b_hs_s) begin
                    bready_d    = 1'b0;
                    err_d       = err_q | (m_axi.bresp != RESP_OKAY);
                    remaining_d = nxt_rem_s;
                    if (nxt_rem_s != 16'd0) begin
                        state_d   = ST_AW;
                        awaddr_d  = nxt_addr_s;
                        awlen_d   = 8'(nxt_beats_s - 9'd1);
                        beats_d   = nxt_beats_s;
                        awvalid_d = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    state_d = ST_B;
                end
            end
            ST_DONE: begin
                // A zero-length start arrives here with done_q low and pulses
                // one cycle later; a normal finish arrives with done_q high.
                if (done_q) begin
                    done_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Buffer prefetch with credits: FIFO entries plus reads not yet pushed.
    always_comb begin
        if (start_acc_s) begin
            wtr_d     = length;
            rd_addr_d = src_addr;
            used_d    = '0;
        end else begin
            wtr_d     = wtr_q - 16'(rd_en_q);
            rd_addr_d = rd_addr_q + ADDR_WIDTH'(rd_en_q);
            used_d    = used_q + (CW+1)'(rd_en_q) - (CW+1)'(fifo_pop_s);
        end
        rd_en_d = (wtr_d != 16'd0) && (used_d < (CW+1)'(FIFO_DEPTH));
        push_d  = rd_en_q;
    end

    // All control and output registers; reset abandons any transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            remaining_q <= 16'd0;
            beats_q     <= 9'd0;
            pop_cnt_q   <= 9'd0;
            awaddr_q    <= 32'd0;
            awlen_q     <= 8'd0;
            awsize_q    <= 3'd0;
            awburst_q   <= 2'd0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            wlast_q     <= 1'b0;
            bready_q    <= 1'b0;
            wtr_q       <= 16'd0;
            used_q      <= '0;
            rd_en_q     <= 1'b0;
            push_q      <= 1'b0;
            rd_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            remaining_q <= remaining_d;
            beats_q     <= beats_d;
            pop_cnt_q   <= pop_cnt_d;
            awaddr_q    <= awaddr_d;
            awlen_q     <= awlen_d;
            awsize_q    <= awsize_d;
            awburst_q   <= awburst_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            wlast_q     <= wlast_d;
            bready_q    <= bready_d;
            wtr_q       <= wtr_d;
            used_q      <= used_d;
            rd_en_q     <= rd_en_d;
            push_q      <= push_d;
            rd_addr_q   <= rd_addr_d;
        end
    end

    assign done_irq      = done_q;
    assign busy          = busy_q;
    assign err_bresp     = err_q;
    assign buf_rd_en     = rd_en_q;
    assign buf_rd_addr   = rd_addr_q;
    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.awlen   = awlen_q;
    assign m_axi.awsize  = awsize_q;
    assign m_axi.awburst = awburst_q;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = fifo_rd_data_s;
    assign m_axi.wstrb   = {(DATA_WIDTH/8){1'b1}};
    assign m_axi.wlast   = wlast_q;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
endmodule

// File: tb/tb_axi_writeback_dma.sv
// Directed bench for axi_writeback_dma: a table of transfers with expected
// burst layout, plus hand-written reset, zero-length and mid-W reset cases.
module tb_axi_writeback_dma;
    localparam int AW_B = 10;
    localparam int DW   = 32;
    localparam int FD   = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start_pulse = 1'b0;
    logic [31:0]     dest_addr = 32'd0;
    logic [AW_B-1:0] src_addr = '0;
    logic [15:0]     length = 16'd0;
    logic            done_irq, busy, err_bresp, buf_rd_en;
    logic [AW_B-1:0] buf_rd_addr;
    logic [DW-1:0]   buf_rd_data = '0;

    int n_checks = 0;
    int n_errors = 0;

    axi_writeback_dma_if #(.DATA_WIDTH(DW)) axi ();

    axi_writeback_dma #(
        .ADDR_WIDTH (AW_B),
        .DATA_WIDTH (DW),
        .MAX_BURST  (16),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_pulse (start_pulse),
        .dest_addr   (dest_addr),
        .src_addr    (src_addr),
        .length      (length),
        .done_irq    (done_irq),
        .busy        (busy),
        .err_bresp   (err_bresp),
        .buf_rd_en   (buf_rd_en),
        .buf_rd_addr (buf_rd_addr),
        .buf_rd_data (buf_rd_data),
        .m_axi       (axi)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] buf_word(input logic [AW_B-1:0] a);
        return 32'hDA7A_0000 | 32'(a);
    endfunction

    // Unified-buffer model: data one cycle after the read strobe.
    always_ff @(posedge clk) begin
        if (buf_rd_en) buf_rd_data <= buf_word(buf_rd_addr);
    end

    typedef struct packed {
        logic [31:0]      dest;
        logic [AW_B-1:0]  src;
        logic [15:0]      len;
        logic             stall;
        int               err_burst;
        int               nb;
        logic [2:0][31:0] aw_addr;
        logic [2:0][7:0]  aw_len;
        logic             exp_err;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] dest, input logic [AW_B-1:0] src,
                                input logic [15:0] len, input logic stall, input int errb,
                                input int nb, input logic [31:0] a0, input logic [7:0] l0,
                                input logic [31:0] a1, input logic [7:0] l1,
                                input logic [31:0] a2, input logic [7:0] l2,
                                input logic exp_err);
        vec_t v;
        v.dest = dest; v.src = src; v.len = len; v.stall = stall;
        v.err_burst = errb; v.nb = nb; v.exp_err = exp_err;
        v.aw_addr[0] = a0; v.aw_len[0] = l0;
        v.aw_addr[1] = a1; v.aw_len[1] = l1;
        v.aw_addr[2] = a2; v.aw_len[2] = l2;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_done"},    64'(done_irq),      64'd0);
        check({tag, "_busy"},    64'(busy),          64'd0);
        check({tag, "_err"},     64'(err_bresp),     64'd0);
        check({tag, "_rd_en"},   64'(buf_rd_en),     64'd0);
        check({tag, "_rd_addr"}, 64'(buf_rd_addr),   64'd0);
        check({tag, "_awvalid"}, 64'(axi.awvalid),   64'd0);
        check({tag, "_awaddr"},  64'(axi.awaddr),    64'd0);
        check({tag, "_awlen"},   64'(axi.awlen),     64'd0);
        check({tag, "_wvalid"},  64'(axi.wvalid),    64'd0);
        check({tag, "_wlast"},   64'(axi.wlast),     64'd0);
        check({tag, "_bready"},  64'(axi.bready),    64'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one transfer with a responding AXI slave and scoreboard.
    task automatic run_vec(input vec_t v);
        int cyc, n_aw, n_b, n_beat, beat_in, cur_beats, reads, last_b_cyc;
        bit b_owed, aw_stall, w_stall, done_seen, err_chk, clear_b, exp_err_now;
        logic [31:0] aw_p_addr, w_p_data;
        logic [7:0]  aw_p_len;
        logic        w_p_last;
        n_aw = 0; n_b = 0; n_beat = 0; beat_in = 0; cur_beats = 0; reads = 0;
        last_b_cyc = -10; b_owed = 0; aw_stall = 0; w_stall = 0; done_seen = 0;
        err_chk = 0; clear_b = 0; exp_err_now = 0;
        aw_p_addr = 32'd0; w_p_data = 32'd0; aw_p_len = 8'd0; w_p_last = 1'b0;
        @(negedge clk);
        start_pulse = 1'b1; dest_addr = v.dest; src_addr = v.src; length = v.len;
        tick();
        start_pulse = 1'b0;
        check("start_busy",    64'(busy),        64'd1);
        check("start_awvalid", 64'(axi.awvalid), 64'd1);
        check("start_rd_en",   64'(buf_rd_en),   64'd1);
        check("start_err_clr", 64'(err_bresp),   64'd0);
        cyc = 1;
        while (!done_seen && cyc < 3000) begin
            axi.awready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            axi.wready  = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (b_owed && !axi.bvalid) begin
                axi.bvalid = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
                axi.bresp  = (n_b == v.err_burst) ? 2'b10 : 2'b00;
            end
            if (err_chk) begin
                check("err_bresp_after_b", 64'(err_bresp), 64'(exp_err_now));
                err_chk = 0;
            end
            if (cyc < 3) check("wvalid_early", 64'(axi.wvalid), 64'd0);
            if (buf_rd_en) begin
                check("rd_addr", 64'(buf_rd_addr), 64'(AW_B'(v.src + AW_B'(reads))));
                reads++;
                check("fifo_credit", 64'((reads - n_beat) <= FD + 1), 64'd1);
            end
            if (aw_stall) begin
                check("aw_hold_valid", 64'(axi.awvalid), 64'd1);
                check("aw_hold_addr",  64'(axi.awaddr),  64'(aw_p_addr));
                check("aw_hold_len",   64'(axi.awlen),   64'(aw_p_len));
            end
            aw_stall = 0;
            if (axi.awvalid && axi.awready) begin
                if (n_aw < v.nb) begin
                    check("awaddr",  64'(axi.awaddr),  64'(v.aw_addr[n_aw]));
                    check("awlen",   64'(axi.awlen),   64'(v.aw_len[n_aw]));
                    check("awsize",  64'(axi.awsize),  64'd2);
                    check("awburst", 64'(axi.awburst), 64'd1);
                    cur_beats = int'(v.aw_len[n_aw]) + 1;
                end else begin
                    check("extra_aw", 64'(n_aw), 64'(v.nb - 1));
                end
                beat_in = 0;
                n_aw++;
            end else if (axi.awvalid) begin
                aw_stall = 1; aw_p_addr = axi.awaddr; aw_p_len = axi.awlen;
            end else begin
                aw_stall = 0;
            end
            if (w_stall) begin
                check("w_hold_valid", 64'(axi.wvalid), 64'd1);
                check("w_hold_data",  64'(axi.wdata),  64'(w_p_data));
                check("w_hold_last",  64'(axi.wlast),  64'(w_p_last));
            end
            w_stall = 0;
            if (axi.wvalid && axi.wready) begin
                check("wdata", 64'(axi.wdata), 64'(buf_word(AW_B'(v.src + AW_B'(n_beat)))));
                check("wlast", 64'(axi.wlast), 64'(beat_in == cur_beats - 1));
                check("wstrb", 64'(axi.wstrb), 64'hF);
                if (axi.wlast) b_owed = 1;
                n_beat++;
                beat_in++;
            end else if (axi.wvalid) begin
                w_stall = 1; w_p_data = axi.wdata; w_p_last = axi.wlast;
            end else begin
                w_stall = 0;
            end
            if (axi.bvalid && axi.bready) begin
                n_b++;
                last_b_cyc  = cyc;
                exp_err_now = (v.err_burst >= 0) && (n_b - 1 >= v.err_burst);
                err_chk = 1; b_owed = 0; clear_b = 1;
            end
            if (done_irq) begin
                done_seen = 1;
                check("done_timing", 64'(cyc),       64'(last_b_cyc + 1));
                check("done_busy",   64'(busy),      64'd0);
                check("n_bursts",    64'(n_aw),      64'(v.nb));
                check("n_bresp",     64'(n_b),       64'(v.nb));
                check("n_beats",     64'(n_beat),    64'(v.len));
                check("n_reads",     64'(reads),     64'(v.len));
                check("final_err",   64'(err_bresp), 64'(v.exp_err));
            end
            tick();
            cyc++;
            if (clear_b) begin
                axi.bvalid = 1'b0;
                clear_b = 0;
            end
        end
        check("done_seen", 64'(done_seen), 64'd1);
        check("done_one_cycle", 64'(done_irq), 64'd0);
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    endtask

    vec_t vecs[6];

    initial begin
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;

        //            dest         src     len    stall err nb  burst0            burst1            burst2            err
        vecs[0] = mk(32'h1000, 10'h010, 16'd5,  1'b0, -1, 1, 32'h1000, 8'd4,  32'h0,    8'd0,  32'h0,    8'd0, 1'b0);
        vecs[1] = mk(32'h0000, 10'h100, 16'd40, 1'b0, -1, 3, 32'h0000, 8'd15, 32'h0040, 8'd15, 32'h0080, 8'd7, 1'b0);
        vecs[2] = mk(32'h0FF8, 10'h3FE, 16'd6,  1'b0, -1, 2, 32'h0FF8, 8'd1,  32'h1000, 8'd3,  32'h0,    8'd0, 1'b0);
        vecs[3] = mk(32'h2000, 10'h200, 16'd37, 1'b1, -1, 3, 32'h2000, 8'd15, 32'h2040, 8'd15, 32'h2080, 8'd4, 1'b0);
        vecs[4] = mk(32'h3000, 10'h020, 16'd40, 1'b0,  1, 3, 32'h3000, 8'd15, 32'h3040, 8'd15, 32'h3080, 8'd7, 1'b1);
        vecs[5] = mk(32'h4003, 10'h000, 16'd3,  1'b0, -1, 1, 32'h4000, 8'd2,  32'h0,    8'd0,  32'h0,    8'd0, 1'b0);

        repeat (3) tick();
        check_idle("reset");
        rst = 1'b0;
        tick();
        check_idle("post_reset");

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Zero-length request: done two cycles after start, no activity.
        @(negedge clk);
        start_pulse = 1'b1; dest_addr = 32'h5000; src_addr = 10'h050; length = 16'd0;
        tick();
        start_pulse = 1'b0;
        check("z_t1_busy",    64'(busy),        64'd1);
        check("z_t1_done",    64'(done_irq),    64'd0);
        check("z_t1_awvalid", 64'(axi.awvalid), 64'd0);
        check("z_t1_rd_en",   64'(buf_rd_en),   64'd0);
        tick();
        check("z_t2_done",    64'(done_irq),    64'd1);
        check("z_t2_busy",    64'(busy),        64'd0);
        check("z_t2_awvalid", 64'(axi.awvalid), 64'd0);
        check("z_t2_rd_en",   64'(buf_rd_en),   64'd0);
        tick();
        check("z_t3_done",    64'(done_irq),    64'd0);
        check("z_t3_wvalid",  64'(axi.wvalid),  64'd0);

        // Reset while a W beat is stalled, then a fresh transfer.
        @(negedge clk);
        start_pulse = 1'b1; dest_addr = 32'h0; src_addr = 10'h100; length = 16'd40;
        axi.awready = 1'b1; axi.wready = 1'b0;
        tick();
        start_pulse = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (!axi.wvalid) tick();
        end
        check("midw_wvalid_seen", 64'(axi.wvalid), 64'd1);
        check("midw_busy",        64'(busy),       64'd1);
        rst = 1'b1;
        tick();
        check_idle("midw_rst");
        rst = 1'b0;
        axi.awready = 1'b0;
        tick();
        check_idle("midw_release");
        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
